poly_ram_ctrl: RTL

Memory-side responder for the polynomial arithmetic engine. Owns two 512×16 coefficient banks (A, B). A host loads and unloads them over valid/ready streams, and the arithmetic engine reads both banks in lockstep and writes results back into bank A. Sits between the top-level command/stream path and the arithmetic engine; it issues the engine's start and collects its done.

---
 rtl/poly_pkg.sv | 21 ++
 rtl/poly_bank_ram.sv | 48 ++++
 rtl/poly_ram_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_pkg.sv
// poly_pkg: shared sizing, command encoding and controller state type
// for the polynomial coefficient RAM controller.
package poly_pkg;

  localparam int N  = 512;
  localparam int W  = 16;
  localparam int AW = 9;

  localparam logic [1:0] CMD_LOAD_A = 2'b00;
  localparam logic [1:0] CMD_LOAD_B = 2'b01;
  localparam logic [1:0] CMD_RUN    = 2'b10;
  localparam logic [1:0] CMD_READ_A = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    READ = 2'b11
  } state_t;

endpackage

// File: rtl/poly_bank_ram.sv
// poly_bank_ram: single-clock simple-dual-port N x W coefficient bank.
// Read data is registered (1-cycle latency) and holds when re is low.
// Array contents are not reset; only the read register is.
module poly_bank_ram #(
  parameter int N  = poly_pkg::N,
  parameter int W  = poly_pkg::W,
  parameter int AW = poly_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];
  logic [W-1:0] rdata_q, rdata_d;

  // Write port: unreset storage array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read select: sample the addressed word when enabled, else hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read register: old contents on a same-address write (read-first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/poly_ram_ctrl.sv
// poly_ram_ctrl: memory-side responder for the polynomial engine.
// Owns coefficient banks A and B; host loads/unloads them over
// valid/ready streams, the engine reads both and writes results to A.
// Optional build macro: POLY_RAM_CTRL_RDFWD_EN (engine write-to-read
// forwarding on bank A; default is read-first).
module poly_ram_ctrl
  import poly_pkg::state_t, poly_pkg::IDLE, poly_pkg::LOAD, poly_pkg::RUN, poly_pkg::READ;
  import poly_pkg::CMD_LOAD_A, poly_pkg::CMD_LOAD_B, poly_pkg::CMD_RUN, poly_pkg::CMD_READ_A;
#(
  parameter int N  = poly_pkg::N,
  parameter int W  = poly_pkg::W,
  parameter int AW = poly_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W-1:0]  m_data,
  output logic          eng_start,
  input  logic          eng_done,
  input  logic          eng_we,
  input  logic [AW-1:0] eng_addr,
  input  logic [W-1:0]  eng_din,
  output logic [W-1:0]  eng_doa,
  output logic [W-1:0]  eng_dob
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(N-1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_t      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW:0] rd_cnt_q, rd_cnt_d;
  logic        sel_b_q, sel_b_d;
  logic        done_q, done_d;
  logic        eng_start_q, eng_start_d;
  logic        s_ready_q, s_ready_d;
  logic        cmd_ready_q, cmd_ready_d;

  // Skid buffer: buf0 is the head presented on m_data.
  logic [1:0]   occ_q, occ_d, occ_p;
  logic         inflight_q, inflight_d;
  logic [W-1:0] buf0_q, buf0_d;
  logic [W-1:0] buf1_q, buf1_d;

  // Engine-side bank A read tracking and hold register.
  logic         eng_rd_q, eng_rd_d;
  logic [W-1:0] doa_hold_q, doa_hold_d;
  logic [W-1:0] eng_a_rd;

  logic        in_run, in_read, accept, s_hs, m_hs, last;
  logic        rd_start, rd_issue;
  logic [2:0]  rd_level;

  logic          a_we, a_re, b_we, b_re;
  logic [AW-1:0] a_waddr, a_raddr, b_waddr;
  logic [W-1:0]  a_wdata, a_rdata, b_rdata;

  // Handshake decode and read-issue gating.
  always_comb begin
    in_run   = (state_q == RUN);
    in_read  = (state_q == READ);
    accept   = cmd_valid & cmd_ready_q;
    s_hs     = (state_q == LOAD) & s_valid & s_ready_q;
    m_hs     = in_read & m_valid & m_ready;
    last     = (cnt_q == LAST_IDX);
    // The first READ_A fetch is launched on the accept cycle so m_valid
    // appears two cycles after the command.
    rd_start = accept & (cmd == CMD_READ_A);
    // Occupancy after this cycle's pop, including the word in flight.
    rd_level = 3'(occ_q) + 3'(inflight_q) - 3'(m_hs);
    rd_issue = rd_start | (in_read & ~rd_cnt_q[AW] & (rd_level < 3'd2));
  end

  // Next-state, counters, done/start pulses and skid buffer update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_cnt_d    = rd_cnt_q;
    sel_b_d     = sel_b_q;
    done_d      = 1'b0;
    eng_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          rd_cnt_d = '0;
          case (cmd)
            CMD_LOAD_A: begin
              state_d = LOAD;
              sel_b_d = 1'b0;
            end
            CMD_LOAD_B: begin
              state_d = LOAD;
              sel_b_d = 1'b1;
            end
            CMD_RUN: begin
              state_d     = RUN;
              eng_start_d = 1'b1;
            end
            default: begin
              state_d  = READ;
              rd_cnt_d = CNT_ONE;
            end
          endcase
        end
      end
      LOAD: begin
        if (s_hs) begin
          cnt_d = cnt_q + CNT_ONE;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (eng_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      READ: begin
        if (rd_issue) begin
          rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
        if (m_hs) begin
          cnt_d = cnt_q + CNT_ONE;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d   = (state_d == LOAD);
    cmd_ready_d = (state_d == IDLE);

    // Pop first, then append the returning RAM word at the new tail.
    occ_p  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (m_hs) begin
      occ_p = occ_q - 2'd1;
      if (occ_q == 2'd2) begin
        buf0_d = buf1_q;
      end
    end
    if (inflight_q) begin
      if (occ_p == 2'd0) begin
        buf0_d = a_rdata;
      end else begin
        buf1_d = a_rdata;
      end
      occ_p = occ_p + 2'd1;
    end
    occ_d      = occ_p;
    inflight_d = rd_issue;

    eng_rd_d   = in_run;
    doa_hold_d = eng_doa;
  end

  // Bank port muxing: engine owns both banks in RUN, host otherwise.
  always_comb begin
    a_we    = (s_hs & ~sel_b_q) | (in_run & eng_we);
    a_waddr = in_run ? eng_addr : cnt_q[AW-1:0];
    a_wdata = in_run ? eng_din : s_data;
    a_re    = in_run | rd_issue;
    a_raddr = in_run ? eng_addr : (rd_start ? '0 : rd_cnt_q[AW-1:0]);
    b_we    = s_hs & sel_b_q;
    b_waddr = cnt_q[AW-1:0];
    b_re    = in_run;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      sel_b_q     <= 1'b0;
      done_q      <= 1'b0;
      eng_start_q <= 1'b0;
      s_ready_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      eng_rd_q    <= 1'b0;
      doa_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      sel_b_q     <= sel_b_d;
      done_q      <= done_d;
      eng_start_q <= eng_start_d;
      s_ready_q   <= s_ready_d;
      cmd_ready_q <= cmd_ready_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      eng_rd_q    <= eng_rd_d;
      doa_hold_q  <= doa_hold_d;
    end
  end

`ifdef POLY_RAM_CTRL_RDFWD_EN
  logic         fwd_q, fwd_d;
  logic [W-1:0] fwd_data_q, fwd_data_d;

  // Engine read and write share eng_addr, so any engine write forwards.
  always_comb begin
    fwd_d      = in_run & eng_we;
    fwd_data_d = eng_din;
  end

  // Forwarding capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign eng_a_rd = fwd_q ? fwd_data_q : a_rdata;
`else
  assign eng_a_rd = a_rdata;
`endif

  poly_bank_ram #(.N(N), .W(W), .AW(AW)) u_bank_a (
    .clk   (clk),
    .rst   (rst),
    .we    (a_we),
    .waddr (a_waddr),
    .wdata (a_wdata),
    .re    (a_re),
    .raddr (a_raddr),
    .rdata (a_rdata)
  );

  poly_bank_ram #(.N(N), .W(W), .AW(AW)) u_bank_b (
    .clk   (clk),
    .rst   (rst),
    .we    (b_we),
    .waddr (b_waddr),
    .wdata (s_data),
    .re    (b_re),
    .raddr (eng_addr),
    .rdata (b_rdata)
  );

  // Bank A's read register is shared with READ_A, so eng_doa shows it
  // only for engine-issued reads and otherwise replays its last value.
  assign eng_doa   = eng_rd_q ? eng_a_rd : doa_hold_q;
  assign eng_dob   = b_rdata;
  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign eng_start = eng_start_q;
  assign s_ready   = s_ready_q;
  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf0_q;

endmodule
